branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//  Branch resolution controller for the ID stage of the pipelined MIPS core.
//  It holds a branch in ID until its forwarded operands are ready, then latches them.
//  It evaluates the branch condition (eq/ne plus sign tests against zero) and issues a one-cycle redirect to IF.
//  It also keeps branch and taken statistics, and flags branches that wait too long.
// PARAMETERS
//  MAX_WAIT  8   WAIT-state cycles before the sticky err_timeout is set (1..255)
//  CNT_W     16  width of the br_cnt / taken_cnt statistic counters
// PORTS
//  clk            in   1      core clock, rising edge
//  reset          in   1      asynchronous, active-low reset
//  br_valid       in   1      ID stage holds a branch instruction
//  br_op          in   3      000 beq, 001 bne, 010 blez, 011 bgtz, 100 bltz, 101 bgez, 11x never taken
//  rs_val         in   32     forwarded rs value
//  rt_val         in   32     forwarded rt value
//  rs_ready       in   1      rs value is final (no pending producer)
//  rt_ready       in   1      rt value is final
//  br_target      in   32     PC + 4 + (sign-extended imm << 2), computed in ID
//  flush          in   1      exception/eret kill; aborts the branch in flight
//  stall          out  1      freeze PC and IF/ID
//  redirect_valid out  1      one-cycle pulse: branch taken
//  redirect_pc    out  32     target PC; valid only while redirect_valid=1
//  br_cnt         out  CNT_W  branches resolved, wrapping
//  taken_cnt      out  CNT_W  branches taken, wrapping
//  err_timeout    out  1      sticky; set when operands are not ready within MAX_WAIT cycles
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE, stall=0, redirect_valid=0, redirect_pc=0, br_cnt=0, taken_cnt=0,
//     err_timeout=0, wait_cnt=0, operand regs=0.
//  Operand need:
//   - beq/bne need rs_ready & rt_ready.
//   - blez/bgtz/bltz/bgez need rs_ready only; rt_ready is ignored.
//  States:
//   - IDLE: stall = br_valid (combinational).
//     - br_valid & ready: latch rs/rt/op/target -> EVAL.
//     - br_valid & !ready: -> WAIT, wait_cnt=0.
//     - Otherwise stay in IDLE.
//   - WAIT: stall=1 and wait_cnt++ each cycle (saturating).
//     - When ready: latch -> EVAL.
//     - When wait_cnt reaches MAX_WAIT: set err_timeout; keep waiting (no forced exit).
//   - EVAL: stall=0; the condition is evaluated on the latched operands.
//     - Condition taken: redirect_valid=1, redirect_pc=latched target.
//     - br_cnt+1; taken_cnt+1 if taken.
//     - Next state is always IDLE. A br_valid during EVAL is the delay slot and is ignored.
//  Registers:
//   - redirect_valid and redirect_pc are driven from registered state: the pulse lasts exactly the EVAL cycle.
//   - Minimum latency from br_valid to redirect is 1 cycle (IDLE latch, then EVAL).
//  Conditions (latched values):
//   - eq: rs==rt. ne: rs!=rt.
//   - blez: $signed(rs)<=0. bgtz: $signed(rs)>0.
//   - bltz: rs[31]. bgez: !rs[31].
//  flush (highest priority, synchronous):
//   - -> IDLE from any state; stall=0 and redirect_valid=0 that cycle.
//   - No counter update; wait_cnt cleared; err_timeout kept.
//  Counters:
//   - Wrap modulo 2^CNT_W (all-ones + 1 -> 0).
//   - Simultaneous br/taken increments are independent.
//  Reset mid-WAIT or mid-EVAL: immediate return to reset values; no redirect pulse.
// TESTING
//  beq rs=rt=0x1234, both ready -> 1 stall cycle, then redirect_valid=1 for 1 cycle with redirect_pc=br_target; br_cnt=1, taken_cnt=1
//  bne rs=rt=5 -> EVAL without redirect; br_cnt=1, taken_cnt=0
//  blez rs=0x80000000 with rt_ready=0 -> taken (rt ignored); bgtz rs=0 -> not taken
//  beq with rt_ready low for 3 cycles -> stall held 4 cycles total, then redirect; err_timeout stays 0
//  MAX_WAIT=8, rs_ready low for 10 cycles -> err_timeout=1 from cycle 8 on; flush -> IDLE, stall=0, no counter change
//  CNT_W=4, 16 taken branches -> br_cnt and taken_cnt wrap to 0; async reset during WAIT -> all outputs 0 at once

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - ID-stage branch resolution: operand wait, condition eval, IF redirect, stats
module branch_resolve_ctrl #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             br_valid_i,
  input  logic [2:0]       br_op_i,
  input  logic [31:0]      rs_val_i,
  input  logic [31:0]      rt_val_i,
  input  logic             rs_ready_i,
  input  logic             rt_ready_i,
  input  logic [31:0]      br_target_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o,
  output logic             err_timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EVAL} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      rs_q, rs_d, rt_q, rt_d, tgt_q, tgt_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, taken_cnt_q, taken_cnt_d;
  logic             err_q, err_d;
  logic             ops_ready, taken, latch, stall, redirect;

  // Only beq/bne compare against rt; every other op reads rs alone.
  assign ops_ready = rs_ready_i & (rt_ready_i | (br_op_i[2:1] != 2'b00));

  always_comb begin
    taken = 1'b0;
    case (op_q)
      3'b000:  taken = (rs_q == rt_q);
      3'b001:  taken = (rs_q != rt_q);
      3'b010:  taken = rs_q[31] | (rs_q == 32'd0);
      3'b011:  taken = ~rs_q[31] & (rs_q != 32'd0);
      3'b100:  taken = rs_q[31];
      3'b101:  taken = ~rs_q[31];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    tgt_d       = tgt_q;
    wait_cnt_d  = wait_cnt_q;
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    err_d       = err_q;
    stall       = 1'b0;
    redirect    = 1'b0;
    latch       = 1'b0;

    if (flush_i) begin
      state_d    = S_IDLE;
      wait_cnt_d = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          stall = br_valid_i;
          if (br_valid_i) begin
            if (ops_ready) begin
              latch   = 1'b1;
              state_d = S_EVAL;
            end else begin
              state_d    = S_WAIT;
              wait_cnt_d = 8'd0;
            end
          end
        end
        S_WAIT: begin
          stall = 1'b1;
          if (ops_ready) begin
            latch   = 1'b1;
            state_d = S_EVAL;
          end else begin
            if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
            if ({24'd0, wait_cnt_q} >= MAX_WAIT - 1) err_d = 1'b1;
          end
        end
        S_EVAL: begin
          // Any br_valid seen here is the delay slot, not a new branch.
          redirect = taken;
          br_cnt_d = br_cnt_q + CNT_W'(1);
          if (taken) taken_cnt_d = taken_cnt_q + CNT_W'(1);
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (latch) begin
      op_d  = br_op_i;
      rs_d  = rs_val_i;
      rt_d  = rt_val_i;
      tgt_d = br_target_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      rs_q        <= 32'd0;
      rt_q        <= 32'd0;
      tgt_q       <= 32'd0;
      wait_cnt_q  <= 8'd0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      tgt_q       <= tgt_d;
      wait_cnt_q  <= wait_cnt_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
      err_q       <= err_d;
    end
  end

  // Stall is gated by reset so all outputs drop together even with br_valid held.
  assign stall_o          = stall & rst_ni;
  assign redirect_valid_o = redirect;
  assign redirect_pc_o    = redirect ? tgt_q : 32'd0;
  assign br_cnt_o         = br_cnt_q;
  assign taken_cnt_o      = taken_cnt_q;
  assign err_timeout_o    = err_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - randomized bench for branch_resolve_ctrl against a transaction-level model
module tb_branch_resolve_ctrl;

  localparam int unsigned MAXW = 8;
  localparam int unsigned CW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          br_valid = 1'b0;
  logic [2:0]    br_op = 3'd0;
  logic [31:0]   rs_val = 32'd0, rt_val = 32'd0, br_target = 32'd0;
  logic          rs_ready = 1'b0, rt_ready = 1'b0, flush = 1'b0;
  logic          stall, redirect_valid, err_timeout;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] br_cnt, taken_cnt;

  int tests = 0;
  int fails = 0;
  int unsigned br_m = 0, tk_m = 0;
  bit err_m = 1'b0;

  branch_resolve_ctrl #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .br_valid_i(br_valid), .br_op_i(br_op),
    .rs_val_i(rs_val), .rt_val_i(rt_val), .rs_ready_i(rs_ready), .rt_ready_i(rt_ready),
    .br_target_i(br_target), .flush_i(flush), .stall_o(stall),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
    .br_cnt_o(br_cnt), .taken_cnt_o(taken_cnt), .err_timeout_o(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int signed s;
    s = rs;
    case (op)
      3'd0: return rs == rt;
      3'd1: return rs != rt;
      3'd2: return s <= 0;
      3'd3: return s > 0;
      3'd4: return s < 0;
      3'd5: return s >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_outputs(input bit exp_stall, input bit exp_rv, input logic [31:0] exp_pc);
    expect_eq("stall", stall, exp_stall);
    expect_eq("redirect_valid", redirect_valid, exp_rv);
    if (exp_rv) expect_eq("redirect_pc", redirect_pc, exp_pc);
    expect_eq("br_cnt", br_cnt, br_m % (1 << CW));
    expect_eq("taken_cnt", taken_cnt, tk_m % (1 << CW));
    expect_eq("err_timeout", err_timeout, err_m);
  endtask

  task automatic check_reset_state(input string tag);
    br_m = 0; tk_m = 0; err_m = 1'b0;
    expect_eq({tag, "_stall"}, stall, 1'b0);
    expect_eq({tag, "_rv"}, redirect_valid, 1'b0);
    expect_eq({tag, "_pc"}, redirect_pc, 32'd0);
    check_outputs(1'b0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; br_valid = 1'b0; flush = 1'b0;
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One branch: nwait cycles with operands not ready, one ready cycle, the EVAL cycle, one idle cycle.
  task automatic run_branch(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] tgt, input int nwait, input int flush_at);
    int  wait_nr = 0;
    bit  aborted = 1'b0;
    bit  needs_rt, tk;
    int  k;
    needs_rt = (op == 3'd0) || (op == 3'd1);
    for (int c = 0; c <= nwait; c++) begin
      @(negedge clk);
      br_valid = 1'b1; br_op = op; flush = (c == flush_at);
      if (c < nwait) begin
        rs_val = $urandom; rt_val = $urandom; br_target = $urandom;
        if (needs_rt) begin
          k = $urandom_range(0, 2);
          rs_ready = (k == 1); rt_ready = (k == 0);
        end else begin
          rs_ready = 1'b0; rt_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        rs_val = rs; rt_val = rt; br_target = tgt; rs_ready = 1'b1;
        rt_ready = needs_rt ? 1'b1 : 1'($urandom_range(0, 1));
      end
      #1;
      check_outputs(!flush, 1'b0, 32'd0);
      if (flush) begin
        aborted = 1'b1;
        break;
      end
      if (c >= 1 && c < nwait) wait_nr++;
      if (wait_nr >= int'(MAXW)) err_m = 1'b1;
    end
    if (!aborted) begin
      @(negedge clk);
      br_valid = 1'($urandom_range(0, 1)); br_op = 3'($urandom);
      rs_val = $urandom; rt_val = $urandom; br_target = $urandom;
      rs_ready = 1'($urandom_range(0, 1)); rt_ready = 1'($urandom_range(0, 1));
      flush = (flush_at == nwait + 1);
      tk = model_taken(op, rs, rt);
      #1;
      check_outputs(1'b0, tk && !flush, tgt);
      if (!flush) begin
        br_m++;
        if (tk) tk_m++;
      end
    end
    @(negedge clk);
    br_valid = 1'b0; flush = 1'b0; rs_ready = 1'b0; rt_ready = 1'b0;
    #1;
    check_outputs(1'b0, 1'b0, 32'd0);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  op;
    logic [31:0] rs, rt;
    int          nw, fa;

    #2;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;

    run_branch(3'd0, 32'h1234, 32'h1234, 32'h0040_0100, 0, -1);
    run_branch(3'd1, 32'd5, 32'd5, 32'h0040_0200, 0, -1);
    run_branch(3'd2, 32'h8000_0000, 32'h0, 32'h0040_0300, 0, -1);
    run_branch(3'd3, 32'd0, 32'd7, 32'h0040_0400, 0, -1);
    run_branch(3'd0, 32'hABCD, 32'hABCD, 32'h0040_0500, 3, -1);
    run_branch(3'd5, 32'd9, 32'd0, 32'h0040_0600, 10, 10);
    expect_eq("timeout_sticky", err_timeout, 1'b1);

    do_reset();
    for (int i = 0; i < 16; i++) run_branch(3'd0, 32'd3, 32'd3, 32'h1000 + 32'(i) * 4, 0, -1);
    expect_eq("wrap_br", br_cnt, 4'd0);
    expect_eq("wrap_taken", taken_cnt, 4'd0);

    @(negedge clk);
    br_valid = 1'b1; br_op = 3'd0; rs_ready = 1'b0; rt_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    expect_eq("wait_stall", stall, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    br_valid = 1'b0; rst_n = 1'b1;

    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      rs = pick_val();
      rt = ($urandom_range(0, 1) == 1) ? rs : pick_val();
      if (op >= 3'd6) nw = 0;
      else if ($urandom_range(0, 9) == 0) nw = $urandom_range(8, 12);
      else nw = $urandom_range(0, 3);
      fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nw + 1)) : -1;
      run_branch(op, rs, rt, $urandom, nw, fa);
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
